// File: rtl/ita_requant_pipeline_pkg.sv
// Shared requantization types and constants used by the requant pipeline, its lanes and its bus.
package ita_package;

  localparam int unsigned REQUANT_N         = 16;
  localparam int unsigned REQUANT_OUT_W     = 8;
  localparam int unsigned REQUANT_MAX_SHIFT = 31;

  typedef logic        [7:0] requant_const_t;
  typedef logic signed [7:0] requant_t;

  typedef enum logic {
    Signed   = 1'b0,
    Unsigned = 1'b1
  } requant_mode_e;

  typedef logic [REQUANT_N*REQUANT_OUT_W-1:0] requant_oup_t;

endpackage

// File: rtl/ita_requant_pipeline_if.sv
// Beat-level bus of the requant pipeline: accumulator input handshake, constants and output side.
interface ita_requant_pipeline_if import ita_package::*; #(
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = 26,
  parameter int unsigned OUT_W = 8
) ();

  logic                 valid_i;
  logic                 ready_o;
  logic [N*ACC_W-1:0]   acc_i;
  logic                 last_i;
  requant_const_t       requant_mult_i;
  requant_const_t       requant_shift_i;
  requant_t             requant_add_i;
  requant_mode_e        requant_mode_i;
  logic                 valid_o;
  logic                 ready_i;
  logic [N*OUT_W-1:0]   data_o;
  logic                 last_o;
  logic                 busy_o;

  modport slave (
    input  valid_i, acc_i, last_i, requant_mult_i, requant_shift_i, requant_add_i,
           requant_mode_i, ready_i,
    output ready_o, valid_o, data_o, last_o, busy_o
  );

  modport master (
    output valid_i, acc_i, last_i, requant_mult_i, requant_shift_i, requant_add_i,
           requant_mode_i, ready_i,
    input  ready_o, valid_o, data_o, last_o, busy_o
  );

endinterface

// File: rtl/ita_requant_lane.sv
// Combinational per-lane rounding shift (S2) and offset/clip (S3) of the requant pipeline.
// Build option: ITA_REQUANT_ROUND_EN adds round-half-up before the shift; otherwise floor.
module ita_requant_lane import ita_package::*; #(
  parameter int unsigned PROD_W = 35,
  parameter int unsigned OUT_W  = 8
) (
  input  logic signed [PROD_W-1:0] prod_i,
  input  requant_const_t           shift_i,
  output logic signed [PROD_W:0]   q_o,
  input  logic signed [PROD_W:0]   q_i,
  input  requant_t                 add_i,
  input  requant_mode_e            mode_i,
  output logic [OUT_W-1:0]         data_o
);

  localparam int unsigned QW  = PROD_W + 1;
  localparam int unsigned SW  = QW + 1;
  localparam int unsigned SHW = $clog2(REQUANT_MAX_SHIFT + 1);

  localparam logic signed [SW-1:0] SMax = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] SMin = ~SMax;
  localparam logic signed [SW-1:0] UMax = SW'((2 ** OUT_W) - 1);

  logic [SHW-1:0]       w_sh;
  logic signed [SW-1:0] w_s;

  always_comb begin
    w_sh = shift_i[SHW-1:0];
    if (shift_i > requant_const_t'(REQUANT_MAX_SHIFT)) begin
      w_sh = SHW'(REQUANT_MAX_SHIFT);
    end
  end

`ifdef ITA_REQUANT_ROUND_EN
  logic signed [QW-1:0] w_rnd;
  logic signed [QW-1:0] w_sum;

  // Guard bit in QW keeps prod + 2^(sh-1) from wrapping.
  always_comb begin
    w_rnd = '0;
    if (w_sh != '0) begin
      w_rnd[w_sh - SHW'(1)] = 1'b1;
    end
    w_sum = QW'(prod_i) + w_rnd;
    q_o   = w_sum >>> w_sh;
  end
`else
  always_comb begin
    q_o = QW'(prod_i) >>> w_sh;
  end
`endif

  always_comb begin
    w_s    = SW'(q_i) + SW'(add_i);
    data_o = w_s[OUT_W-1:0];
    if (mode_i == Signed) begin
      if (w_s > SMax) begin
        data_o = SMax[OUT_W-1:0];
      end else if (w_s < SMin) begin
        data_o = SMin[OUT_W-1:0];
      end
    end else begin
      if (w_s[SW-1]) begin
        data_o = '0;
      end else if (w_s > UMax) begin
        data_o = UMax[OUT_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ita_requant_pipeline.sv
// Three-stage N-lane requantizer (multiply, rounding shift, add/clip) with per-stage backpressure.
// Rounding is selected at build time by ITA_REQUANT_ROUND_EN (see ita_requant_lane).
module ita_requant_pipeline import ita_package::*; #(
  parameter int unsigned N     = 16,
  parameter int unsigned ACC_W = 26,
  parameter int unsigned OUT_W = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  ita_requant_pipeline_if.slave bus
);

  localparam int unsigned ProdW = ACC_W + 9;
  localparam int unsigned QW    = ProdW + 1;

  logic w_s1_ready, w_s2_ready, w_s3_ready;
  logic r_s1_valid, r_s2_valid, r_s3_valid;

  logic signed [ProdW-1:0] r_s1_prod [N];
  logic                    r_s1_last;
  requant_const_t          r_s1_shift;
  requant_t                r_s1_add;
  requant_mode_e           r_s1_mode;

  logic signed [QW-1:0]    r_s2_q [N];
  logic                    r_s2_last;
  requant_t                r_s2_add;
  requant_mode_e           r_s2_mode;

  logic [OUT_W-1:0]        r_s3_data [N];
  logic                    r_s3_last;

  logic signed [ProdW-1:0] w_prod [N];
  logic signed [QW-1:0]    w_q [N];
  logic [OUT_W-1:0]        w_clip [N];
  logic [N*OUT_W-1:0]      w_data;

  // An empty stage always accepts, so bubbles collapse under a downstream stall.
  always_comb begin
    w_s3_ready = !r_s3_valid || bus.ready_i;
    w_s2_ready = !r_s2_valid || w_s3_ready;
    w_s1_ready = !r_s1_valid || w_s2_ready;
  end

  for (genvar i = 0; i < N; i++) begin : g_lane
    logic signed [ACC_W-1:0] w_acc;
    logic signed [8:0]       w_mult;

    assign w_acc     = bus.acc_i[i*ACC_W +: ACC_W];
    assign w_mult    = {1'b0, bus.requant_mult_i};
    assign w_prod[i] = ProdW'(w_acc) * ProdW'(w_mult);

    ita_requant_lane #(
      .PROD_W (ProdW),
      .OUT_W  (OUT_W)
    ) u_lane (
      .prod_i  (r_s1_prod[i]),
      .shift_i (r_s1_shift),
      .q_o     (w_q[i]),
      .q_i     (r_s2_q[i]),
      .add_i   (r_s2_add),
      .mode_i  (r_s2_mode),
      .data_o  (w_clip[i])
    );
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s1_shift <= '0;
      r_s1_add   <= '0;
      r_s1_mode  <= Signed;
      for (int i = 0; i < N; i++) r_s1_prod[i] <= '0;
    end else if (w_s1_ready) begin
      r_s1_valid <= bus.valid_i;
      if (bus.valid_i) begin
        r_s1_last  <= bus.last_i;
        r_s1_shift <= bus.requant_shift_i;
        r_s1_add   <= bus.requant_add_i;
        r_s1_mode  <= bus.requant_mode_i;
        for (int i = 0; i < N; i++) r_s1_prod[i] <= w_prod[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s2_add   <= '0;
      r_s2_mode  <= Signed;
      for (int i = 0; i < N; i++) r_s2_q[i] <= '0;
    end else if (w_s2_ready) begin
      r_s2_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_s2_last <= r_s1_last;
        r_s2_add  <= r_s1_add;
        r_s2_mode <= r_s1_mode;
        for (int i = 0; i < N; i++) r_s2_q[i] <= w_q[i];
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      for (int i = 0; i < N; i++) r_s3_data[i] <= '0;
    end else if (w_s3_ready) begin
      r_s3_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_s3_last <= r_s2_last;
        for (int i = 0; i < N; i++) r_s3_data[i] <= w_clip[i];
      end
    end
  end

  always_comb begin
    w_data = '0;
    for (int i = 0; i < N; i++) w_data[i*OUT_W +: OUT_W] = r_s3_data[i];
  end

  assign bus.ready_o = w_s1_ready;
  assign bus.valid_o = r_s3_valid;
  assign bus.data_o  = w_data;
  assign bus.last_o  = r_s3_valid & r_s3_last;
  assign bus.busy_o  = r_s1_valid | r_s2_valid | r_s3_valid;

endmodule
